// File: rtl/sfifo_arb_pkg.sv
// Shared types and helpers for the sfifo write arbiter.
package sfifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Bits needed to index 0..value-1, never less than one bit so that
  // degenerate parameters (MAXBURST=1, NREQ=2) still give legal vectors.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sfifo_wr_arb_rr_pick.sv
// Rotating-priority picker: first set request at or above the pointer,
// wrapping around modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_any,
  output logic [IW-1:0]   o_idx
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_off;
  logic [IW:0]     w_sum;

  // Rotate requests so the pointer lands at bit 0, find the lowest set bit, then rotate back.
  always_comb begin
    w_rot = NREQ'({i_req, i_req} >> i_ptr);
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IW + 1)'(NREQ)) w_sum = w_sum - (IW + 1)'(NREQ);
    o_idx = w_sum[IW-1:0];
    o_any = |i_req;
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// Burst-atomic round-robin arbiter sharing one sfifo write port among NREQ producers.
module sfifo_wr_arb
  import sfifo_arb_pkg::*;
#(
  parameter int BW       = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*BW-1:0]       i_req_data,
  input  logic [NREQ-1:0]          i_req_last,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_wr,
  output logic [BW-1:0]            o_wr_data,
  input  logic                     i_full,
  output logic [clog2(NREQ)-1:0]   o_grant,
  output logic                     o_busy
);

  localparam int GW = clog2(NREQ);
  localparam int CW = clog2(MAXBURST);

  arb_state_t      r_state, w_stateNext;
  logic [GW-1:0]   r_grant, w_grantNext;
  logic [GW-1:0]   r_rrPtr, w_rrPtrNext;
  logic [CW-1:0]   r_beatCnt, w_beatCntNext;

  logic            w_any;
  logic [GW-1:0]   w_pick;
  logic [NREQ-1:0] w_sel;
  logic            w_ownValid;
  logic            w_ownLast;
  logic            w_xfer;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (GW)
  ) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rrPtr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  // Select the current owner's valid/last/data; non-owners are invisible.
  always_comb begin
    w_sel      = NREQ'(1) << r_grant;
    w_ownValid = |(i_req_valid & w_sel);
    w_ownLast  = |(i_req_last & w_sel);
    o_wr_data  = BW'(i_req_data >> (int'(r_grant) * BW));
  end

  // Handshake outputs and next-state decisions; only BURST moves data, and never into a full FIFO.
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_rrPtrNext   = r_rrPtr;
    w_beatCntNext = r_beatCnt;
    o_busy        = (r_state == BURST);
    w_xfer        = o_busy && w_ownValid && !i_full;
    o_wr          = w_xfer;
    o_req_ready   = (o_busy && !i_full) ? w_sel : '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grantNext   = w_pick;
          w_rrPtrNext   = (w_pick == GW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
          w_beatCntNext = '0;
          w_stateNext   = BURST;
        end
      end
      BURST: begin
        if (w_xfer) begin
          if (w_ownLast || (r_beatCnt == CW'(MAXBURST - 1))) begin
            w_beatCntNext = '0;
            w_stateNext   = IDLE;
          end else begin
            w_beatCntNext = r_beatCnt + 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State, grant, pointer and beat counter registers; reset drops any burst in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_rrPtr   <= w_rrPtrNext;
      r_beatCnt <= w_beatCntNext;
    end
  end

  assign o_grant = r_grant;

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Directed bench for sfifo_wr_arb with a small FIFO occupancy model (depth 2)
// and per-requester beat queues that hold valid/data until accepted.
module tb_sfifo_wr_arb;
  localparam int BW       = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;
  localparam int GW       = 2;
  localparam int FDEPTH   = 2;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ*BW-1:0]   i_req_data;
  logic [NREQ-1:0]      i_req_last;
  logic [NREQ-1:0]      o_req_ready;
  logic                 o_wr;
  logic [BW-1:0]        o_wr_data;
  logic                 i_full;
  logic [GW-1:0]        o_grant;
  logic                 o_busy;

  logic [8:0]           srcQ [NREQ][$];
  logic [BW-1:0]        wrLog[$];
  logic [GW-1:0]        grantLog[$];
  int                   fifoCount;
  bit                   autoPop;
  bit                   popOnce;
  int                   total;
  int                   bad;

  always #5 i_clk = ~i_clk;

  sfifo_wr_arb #(
    .BW       (BW),
    .NREQ     (NREQ),
    .MAXBURST (MAXBURST)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_wr        (o_wr),
    .o_wr_data   (o_wr_data),
    .i_full      (i_full),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  function automatic bit srcBusy();
    bit b;
    b = 0;
    for (int k = 0; k < NREQ; k++) if (srcQ[k].size() > 0) b = 1;
    return b;
  endfunction

  task automatic applyInputs();
    logic [8:0] b;
    for (int k = 0; k < NREQ; k++) begin
      if (srcQ[k].size() > 0) begin
        b = srcQ[k][0];
        i_req_valid[k]          = 1'b1;
        i_req_data[k*BW +: BW]  = b[7:0];
        i_req_last[k]           = b[8];
      end else begin
        i_req_valid[k]          = 1'b0;
        i_req_data[k*BW +: BW]  = '0;
        i_req_last[k]           = 1'b0;
      end
    end
    i_full = (fifoCount >= FDEPTH);
  endtask

  task automatic clearLogs();
    wrLog.delete();
    grantLog.delete();
  endtask

  // One clock: sample handshakes mid-cycle, let the edge happen, then update the models.
  task automatic step();
    logic [NREQ-1:0] acc;
    logic            wr;
    logic [BW-1:0]   d;
    logic [GW-1:0]   g;
    bit              pop;
    acc = i_req_valid & o_req_ready;
    wr  = o_wr;
    d   = o_wr_data;
    g   = o_grant;
    pop = (autoPop || popOnce) && (fifoCount > 0);
    popOnce = 0;
    total++;
    if (wr && i_full) begin
      bad++;
      $display("[TB] FAIL no_write_when_full: o_wr=%0b while i_full=%0b", wr, i_full);
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NREQ; k++) if (acc[k]) void'(srcQ[k].pop_front());
    if (wr) begin
      wrLog.push_back(d);
      grantLog.push_back(g);
    end
    fifoCount = fifoCount + (wr ? 1 : 0) - (pop ? 1 : 0);
    applyInputs();
    @(negedge i_clk);
    #1;
  endtask

  task automatic runDrain(input int maxCycles, input string name);
    int n;
    n = 0;
    while ((srcBusy() || o_busy) && n < maxCycles) begin
      step();
      n++;
    end
    total++;
    if (srcBusy() || o_busy) begin
      bad++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic resetDut();
    i_reset_n = 1'b0;
    for (int k = 0; k < NREQ; k++) srcQ[k].delete();
    clearLogs();
    fifoCount = 0;
    autoPop   = 1;
    popOnce   = 0;
    applyInputs();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    applyInputs();
    @(negedge i_clk);
    #1;
    total += 4;
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", o_busy); end
    if (o_wr !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr: got %0b expected 0", o_wr); end
    if (o_req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0000", o_req_ready); end
    if (o_grant !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant: got %0d expected 0", o_grant); end
    resetDut();
  endtask

  task automatic test_single_burst();
    logic          eBusy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]    eData [5] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    logic [3:0]    eRdy  [5] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    resetDut();
    srcQ[1].push_back({1'b0, 8'hA1});
    srcQ[1].push_back({1'b0, 8'hA2});
    srcQ[1].push_back({1'b1, 8'hA3});
    applyInputs();
    #1;
    for (int c = 0; c < 5; c++) begin
      total += 3;
      if (o_busy !== eBusy[c]) begin bad++; $display("[TB] FAIL single_busy c%0d: got %0b expected %0b", c, o_busy, eBusy[c]); end
      if (o_wr !== eBusy[c]) begin bad++; $display("[TB] FAIL single_wr c%0d: got %0b expected %0b", c, o_wr, eBusy[c]); end
      if (o_req_ready !== eRdy[c]) begin bad++; $display("[TB] FAIL single_ready c%0d: got %b expected %b", c, o_req_ready, eRdy[c]); end
      if (eBusy[c]) begin
        total += 2;
        if (o_wr_data !== eData[c]) begin bad++; $display("[TB] FAIL single_data c%0d: got %h expected %h", c, o_wr_data, eData[c]); end
        if (o_grant !== 2'd1) begin bad++; $display("[TB] FAIL single_grant c%0d: got %0d expected 1", c, o_grant); end
      end
      step();
    end
    total++;
    if (wrLog.size() != 3) begin bad++; $display("[TB] FAIL single_count: got %0d expected 3", wrLog.size()); end
  endtask

  task automatic test_rr_ptr();
    clearLogs();
    srcQ[1].push_back({1'b1, 8'h11});
    srcQ[3].push_back({1'b1, 8'h33});
    applyInputs();
    runDrain(20, "rr_ptr");
    total++;
    if (wrLog.size() != 2) begin
      bad++; $display("[TB] FAIL rr_ptr_count: got %0d expected 2", wrLog.size());
    end else begin
      total += 4;
      if (wrLog[0] !== 8'h33) begin bad++; $display("[TB] FAIL rr_ptr_first_data: got %h expected 33", wrLog[0]); end
      if (grantLog[0] !== 2'd3) begin bad++; $display("[TB] FAIL rr_ptr_first_grant: got %0d expected 3", grantLog[0]); end
      if (wrLog[1] !== 8'h11) begin bad++; $display("[TB] FAIL rr_ptr_second_data: got %h expected 11", wrLog[1]); end
      if (grantLog[1] !== 2'd1) begin bad++; $display("[TB] FAIL rr_ptr_second_grant: got %0d expected 1", grantLog[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic       ePat  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] eData [4] = '{8'h01, 8'h02, 8'h21, 8'h22};
    logic [1:0] eGnt  [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
    resetDut();
    srcQ[0].push_back({1'b0, 8'h01});
    srcQ[0].push_back({1'b1, 8'h02});
    srcQ[2].push_back({1'b0, 8'h21});
    srcQ[2].push_back({1'b1, 8'h22});
    applyInputs();
    #1;
    for (int c = 0; c < 6; c++) begin
      total++;
      if (o_wr !== ePat[c]) begin bad++; $display("[TB] FAIL b2b_wr c%0d: got %0b expected %0b", c, o_wr, ePat[c]); end
      step();
    end
    runDrain(20, "b2b");
    total++;
    if (wrLog.size() != 4) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d expected 4", wrLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total += 2;
        if (wrLog[i] !== eData[i]) begin bad++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, wrLog[i], eData[i]); end
        if (grantLog[i] !== eGnt[i]) begin bad++; $display("[TB] FAIL b2b_grant%0d: got %0d expected %0d", i, grantLog[i], eGnt[i]); end
      end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] eData [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    clearLogs();
    autoPop   = 0;
    fifoCount = 0;
    for (int i = 0; i < 4; i++) srcQ[3].push_back({(i == 3), eData[i]});
    applyInputs();
    #1;
    step();
    step();
    step();
    for (int c = 3; c < 5; c++) begin
      total += 4;
      if (o_wr !== 1'b0) begin bad++; $display("[TB] FAIL full_wr c%0d: got %0b expected 0", c, o_wr); end
      if (o_req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL full_ready c%0d: got %b expected 0000", c, o_req_ready); end
      if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL full_busy c%0d: got %0b expected 1", c, o_busy); end
      if (o_grant !== 2'd3) begin bad++; $display("[TB] FAIL full_grant c%0d: got %0d expected 3", c, o_grant); end
      if (c == 4) popOnce = 1;
      step();
    end
    total += 3;
    if (o_wr !== 1'b1) begin bad++; $display("[TB] FAIL full_resume_wr: got %0b expected 1", o_wr); end
    if (o_wr_data !== 8'h33) begin bad++; $display("[TB] FAIL full_resume_data: got %h expected 33", o_wr_data); end
    if (o_req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL full_resume_ready: got %b expected 1000", o_req_ready); end
    step();
    total++;
    if (o_wr !== 1'b0) begin bad++; $display("[TB] FAIL full_again_wr: got %0b expected 0", o_wr); end
    popOnce = 1;
    step();
    total++;
    if (o_wr_data !== 8'h34 || o_wr !== 1'b1) begin bad++; $display("[TB] FAIL full_last: got wr=%0b data=%h expected wr=1 data=34", o_wr, o_wr_data); end
    step();
    runDrain(20, "full");
    total++;
    if (wrLog.size() != 4) begin
      bad++; $display("[TB] FAIL full_count: got %0d expected 4", wrLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wrLog[i] !== eData[i]) begin bad++; $display("[TB] FAIL full_data%0d: got %h expected %h", i, wrLog[i], eData[i]); end
      end
    end
    autoPop = 1;
  endtask

  task automatic test_maxburst();
    logic [7:0] eData [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11,
                               8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic [1:0] eGnt  [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                               2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    clearLogs();
    autoPop   = 1;
    fifoCount = 0;
    for (int i = 0; i < 10; i++) srcQ[0].push_back({(i == 9), 8'(i)});
    srcQ[1].push_back({1'b0, 8'h10});
    srcQ[1].push_back({1'b1, 8'h11});
    applyInputs();
    runDrain(80, "maxburst");
    total++;
    if (wrLog.size() != 12) begin
      bad++; $display("[TB] FAIL maxburst_count: got %0d expected 12", wrLog.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        total += 2;
        if (wrLog[i] !== eData[i]) begin bad++; $display("[TB] FAIL maxburst_data%0d: got %h expected %h", i, wrLog[i], eData[i]); end
        if (grantLog[i] !== eGnt[i]) begin bad++; $display("[TB] FAIL maxburst_grant%0d: got %0d expected %0d", i, grantLog[i], eGnt[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] eData [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    resetDut();
    for (int k = 0; k < NREQ; k++) begin
      srcQ[k].push_back({1'b1, 8'(k * 16)});
      srcQ[k].push_back({1'b1, 8'(k * 16 + 1)});
    end
    applyInputs();
    runDrain(60, "wrap");
    total++;
    if (wrLog.size() != 8) begin
      bad++; $display("[TB] FAIL wrap_count: got %0d expected 8", wrLog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total += 2;
        if (grantLog[i] !== 2'(i % 4)) begin bad++; $display("[TB] FAIL wrap_grant%0d: got %0d expected %0d", i, grantLog[i], i % 4); end
        if (wrLog[i] !== eData[i]) begin bad++; $display("[TB] FAIL wrap_data%0d: got %h expected %h", i, wrLog[i], eData[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clearLogs();
    for (int i = 0; i < 5; i++) srcQ[2].push_back({(i == 4), 8'(8'h51 + i)});
    applyInputs();
    #1;
    step();
    step();
    step();
    total += 2;
    if (o_busy !== 1'b1 || o_wr !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre: got busy=%0b wr=%0b expected 1/1", o_busy, o_wr); end
    if (wrLog.size() != 2) begin bad++; $display("[TB] FAIL midrst_written: got %0d expected 2", wrLog.size()); end
    #2;
    i_reset_n = 1'b0;
    #1;
    total += 4;
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %0b expected 0", o_busy); end
    if (o_wr !== 1'b0) begin bad++; $display("[TB] FAIL midrst_wr: got %0b expected 0", o_wr); end
    if (o_req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_ready: got %b expected 0000", o_req_ready); end
    if (o_grant !== 2'd0) begin bad++; $display("[TB] FAIL midrst_grant: got %0d expected 0", o_grant); end
    for (int k = 0; k < NREQ; k++) srcQ[k].delete();
    clearLogs();
    fifoCount = 0;
    applyInputs();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;
    #1;
    total += 2;
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_post_busy: got %0b expected 0", o_busy); end
    if (o_grant !== 2'd0) begin bad++; $display("[TB] FAIL midrst_post_grant: got %0d expected 0", o_grant); end
    srcQ[1].push_back({1'b1, 8'h61});
    srcQ[3].push_back({1'b1, 8'h63});
    applyInputs();
    runDrain(20, "midrst");
    total++;
    if (wrLog.size() != 2) begin
      bad++; $display("[TB] FAIL midrst_post_count: got %0d expected 2", wrLog.size());
    end else begin
      total += 2;
      if (wrLog[0] !== 8'h61) begin bad++; $display("[TB] FAIL midrst_ptr_first: got %h expected 61", wrLog[0]); end
      if (wrLog[1] !== 8'h63) begin bad++; $display("[TB] FAIL midrst_ptr_second: got %h expected 63", wrLog[1]); end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    autoPop     = 1;
    popOnce     = 0;
    fifoCount   = 0;
    i_reset_n   = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    i_full      = 1'b0;
    $display("[TB] starting sfifo_wr_arb directed tests");
    test_reset();
    test_single_burst();
    test_rr_ptr();
    test_back_to_back();
    test_full_stall();
    test_maxburst();
    test_wrap();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfifo_wr_arb.md
# sfifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO (`sfifo`, same BW/LGFLEN) among NREQ independent producers. Grants are burst-atomic: a winning requester keeps the FIFO write port until it presents a `last` beat or hits MAXBURST beats, so packets from different producers never interleave. Sits directly in front of the `sfifo` write port and drives its `i_wr`/`i_data` from FIFO `o_full`.

## Interface
- BW, 8, data width; must equal the FIFO's BW
- NREQ, 4, number of requesters, 2..8
- MAXBURST, 16, max beats per grant before forced re-arbitration, ≥1
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NREQ  per-requester beat valid
- i_req_data  in  NREQ*BW  requester k data at bits [k*BW +: BW]
- i_req_last  in  NREQ  final beat of the requester's burst
- o_req_ready  out  NREQ  beat accepted when valid&&ready on a clock edge
- o_wr  out  1  to FIFO `i_wr`
- o_wr_data  out  BW  to FIFO `i_data`
- i_full  in  1  from FIFO `o_full`
- o_grant  out  clog2(NREQ)  index of current owner (valid when o_busy)
- o_busy  out  1  a grant is held

## Operation
- States: IDLE, BURST.
- IDLE: if any i_req_valid, pick winner = first valid index scanning from rr_ptr upward, wrapping modulo NREQ; register o_grant=winner, rr_ptr=(winner+1) mod NREQ, beat_cnt=0, go BURST. No data moves in IDLE.
- BURST: o_req_ready[o_grant] = !i_full; all other ready bits 0. Transfer = i_req_valid[o_grant] && !i_full. o_wr = transfer; o_wr_data = i_req_data of o_grant (driven regardless of o_wr).
- On each transfer beat_cnt increments. Burst ends (go IDLE) on a transfer with i_req_last[o_grant]=1 or beat_cnt==MAXBURST-1.
- Owner deasserting valid mid-burst: grant held indefinitely; no timeout.
- o_wr never asserts while i_full=1, so the FIFO never sees a dropped write.
- Valid/data/last of non-owners are ignored; requesters must hold valid/data stable until ready.
- beat_cnt width clog2(MAXBURST); MAXBURST=1 means every beat re-arbitrates.
- Reset (async assert): state=IDLE, rr_ptr=0, o_grant=0, beat_cnt=0; o_busy=0, o_wr=0, o_req_ready=0 immediately. Reset mid-burst discards the remainder; the FIFO keeps already-written beats.

## Timing
- Arbitration latency: 1 cycle in IDLE; first beat can transfer on the cycle after the IDLE decision.
- Back-to-back bursts incur exactly one IDLE bubble cycle.
- o_req_ready, o_wr, o_wr_data are combinational from registered state and i_full/i_req_*; no registered data path (FIFO registers the write).
- i_full rising: ready/o_wr drop in the same cycle.
- Simultaneous valid from all NREQ with rr_ptr=p: grant order p, p+1, …, wrapping.

## Structure
- Package `sfifo_arb_pkg`: state encoding (IDLE=0, BURST=1) and a clog2 constant function.
- Sub-module `rr_pick`: combinational rotating-priority picker (inputs: request vector, pointer; outputs: any, index). Instantiated once.
- Top holds state register, rr_ptr, beat_cnt, output muxing.

## Test plan
- NREQ=4, req1 sends 3 beats (0xA1,0xA2,0xA3 last), FIFO empty -> IDLE 1 cycle, o_grant=1, o_wr on 3 consecutive cycles, FIFO reads back A1,A2,A3, state IDLE, rr_ptr=2.
- req0 and req2 both valid from reset, 2-beat bursts each -> req0 served first, one bubble, then req2; no interleaving in FIFO contents.
- LGFLEN=2, req3 sends 6 beats -> after 4 writes i_full=1, o_req_ready[3]=0 and o_wr=0 until a FIFO read, then remaining 2 beats written in order; no beat lost or duplicated.
- MAXBURST=4, req0 streams 10 beats without last while req1 valid -> req0 4 beats, req1 burst, req0 resumes; FIFO holds req0 beats 0–3, req1 beats, req0 beats 4–9.
- NREQ=3, all valid continuously with 1-beat bursts -> grant sequence 0,1,2,0,1,2 (pointer wrap).
- Assert i_reset_n=0 after 2 of 5 beats -> o_busy, o_wr, o_req_ready go 0 asynchronously; after release, state IDLE, o_grant=0, rr_ptr=0.
